// File: rtl/tlul_sram_slave.sv
// rtl/tlul_sram_slave.sv - TL-UL single-beat SRAM slave with one-deep response register
module tlul_sram_slave #(
    parameter int ADDR_W = 10,
    parameter int SRC_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic [2:0]        i_a_opcode,
    input  logic [2:0]        i_a_param,
    input  logic [1:0]        i_a_size,
    input  logic [SRC_W-1:0]  i_a_source,
    input  logic [ADDR_W-1:0] i_a_address,
    input  logic [3:0]        i_a_mask,
    input  logic [31:0]       i_a_data,
    output logic              o_d_valid,
    input  logic              i_d_ready,
    output logic [2:0]        o_d_opcode,
    output logic [2:0]        o_d_param,
    output logic [1:0]        o_d_size,
    output logic [SRC_W-1:0]  o_d_source,
    output logic              o_d_sink,
    output logic [31:0]       o_d_data,
    output logic              o_d_error
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_RESP} state_t;
    state_t state;

    logic [31:0] mem [DEPTH];

    logic              is_get, is_put_full, is_put_part, opc_ok;
    logic              misaligned, mask_bad, req_err, accept, mem_we;
    logic [3:0]        lane_mask;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rd_word;
    logic              unused_param;

    assign unused_param = ^i_a_param;

    assign is_get      = (i_a_opcode == 3'd4);
    assign is_put_full = (i_a_opcode == 3'd0);
    assign is_put_part = (i_a_opcode == 3'd1);
    assign opc_ok      = is_get | is_put_full | is_put_part;
    assign word_idx    = i_a_address[ADDR_W-1:2];
    assign rd_word     = mem[word_idx];

    // Byte lanes a request of this size/address is allowed to touch
    always_comb begin
        lane_mask  = 4'b1111;
        misaligned = 1'b0;
        case (i_a_size)
            2'd0: lane_mask = 4'b0001 << i_a_address[1:0];
            2'd1: begin
                lane_mask  = i_a_address[1] ? 4'b1100 : 4'b0011;
                misaligned = i_a_address[0];
            end
            default: misaligned = |i_a_address[1:0];
        endcase
    end

    assign mask_bad = is_put_full ? (i_a_mask != lane_mask)
                                  : |(i_a_mask & ~lane_mask);
    assign req_err  = !opc_ok || (i_a_size == 2'd3) || misaligned || mask_bad;

    // In RESP the slot frees up in the same cycle the response is taken
    assign o_a_ready = (state == ST_IDLE) || ((state == ST_RESP) && i_d_ready);
    assign accept    = i_a_valid && o_a_ready;
    assign mem_we    = accept && (is_put_full || is_put_part) && !req_err;

    assign o_d_param = 3'd0;
    assign o_d_sink  = 1'b0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_RST;
            o_d_valid  <= 1'b0;
            o_d_opcode <= 3'd0;
            o_d_size   <= 2'd0;
            o_d_source <= '0;
            o_d_data   <= 32'd0;
            o_d_error  <= 1'b0;
        end else begin
            case (state)
                ST_RST: state <= ST_IDLE;
                default: begin
                    if (accept) begin
                        state      <= ST_RESP;
                        o_d_valid  <= 1'b1;
                        o_d_opcode <= is_get ? 3'd1 : 3'd0;
                        o_d_size   <= i_a_size;
                        o_d_source <= i_a_source;
                        o_d_data   <= (is_get && !req_err) ? rd_word : 32'd0;
                        o_d_error  <= req_err;
                    end else if ((state == ST_RESP) && i_d_ready) begin
                        state     <= ST_IDLE;
                        o_d_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            if (i_a_mask[0]) mem[word_idx][7:0]   <= i_a_data[7:0];
            if (i_a_mask[1]) mem[word_idx][15:8]  <= i_a_data[15:8];
            if (i_a_mask[2]) mem[word_idx][23:16] <= i_a_data[23:16];
            if (i_a_mask[3]) mem[word_idx][31:24] <= i_a_data[31:24];
        end
    end
endmodule

// File: tb/tb_tlul_sram_slave.sv
// tb/tb_tlul_sram_slave.sv - directed self-checking bench for tlul_sram_slave
module tb_tlul_sram_slave;
    localparam int ADDR_W = 10;
    localparam int SRC_W  = 4;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_a_valid = 1'b0;
    logic              o_a_ready;
    logic [2:0]        i_a_opcode = 3'd0;
    logic [2:0]        i_a_param = 3'd0;
    logic [1:0]        i_a_size = 2'd0;
    logic [SRC_W-1:0]  i_a_source = '0;
    logic [ADDR_W-1:0] i_a_address = '0;
    logic [3:0]        i_a_mask = 4'd0;
    logic [31:0]       i_a_data = 32'd0;
    logic              o_d_valid;
    logic              i_d_ready = 1'b1;
    logic [2:0]        o_d_opcode;
    logic [2:0]        o_d_param;
    logic [1:0]        o_d_size;
    logic [SRC_W-1:0]  o_d_source;
    logic              o_d_sink;
    logic [31:0]       o_d_data;
    logic              o_d_error;

    int n_checks = 0;
    int n_pass   = 0;

    tlul_sram_slave #(.ADDR_W(ADDR_W), .SRC_W(SRC_W)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
        .i_a_opcode(i_a_opcode), .i_a_param(i_a_param), .i_a_size(i_a_size),
        .i_a_source(i_a_source), .i_a_address(i_a_address), .i_a_mask(i_a_mask),
        .i_a_data(i_a_data),
        .o_d_valid(o_d_valid), .i_d_ready(i_d_ready), .o_d_opcode(o_d_opcode),
        .o_d_param(o_d_param), .o_d_size(o_d_size), .o_d_source(o_d_source),
        .o_d_sink(o_d_sink), .o_d_data(o_d_data), .o_d_error(o_d_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                           input logic [9:0] addr, input logic [3:0] mask, input logic [31:0] data);
        i_a_valid   = 1'b1;
        i_a_opcode  = op;
        i_a_param   = 3'd5;
        i_a_size    = size;
        i_a_source  = src;
        i_a_address = addr;
        i_a_mask    = mask;
        i_a_data    = data;
    endtask

    task automatic check_d(input string tag, input logic [2:0] exp_op, input logic exp_err,
                           input logic [31:0] exp_data, input logic [3:0] src, input logic [1:0] size);
        check({tag, ".valid"},  32'(o_d_valid),  32'd1);
        check({tag, ".opcode"}, 32'(o_d_opcode), 32'(exp_op));
        check({tag, ".error"},  32'(o_d_error),  32'(exp_err));
        check({tag, ".data"},   o_d_data,        exp_data);
        check({tag, ".source"}, 32'(o_d_source), 32'(src));
        check({tag, ".size"},   32'(o_d_size),   32'(size));
        check({tag, ".param_sink"}, 32'({o_d_param, o_d_sink}), 32'd0);
    endtask

    // One request with d_ready high: response exactly one edge later, gone the next
    task automatic xact(input string tag, input logic [2:0] op, input logic [1:0] size,
                        input logic [3:0] src, input logic [9:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [2:0] exp_op, input logic exp_err,
                        input logic [31:0] exp_data);
        i_d_ready = 1'b1;
        drive_a(op, size, src, addr, mask, data);
        #1;
        check({tag, ".a_ready"}, 32'(o_a_ready), 32'd1);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        check_d(tag, exp_op, exp_err, exp_data, src, size);
        @(posedge i_clk); #1;
        check({tag, ".idle"}, 32'(o_d_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.d_valid", 32'(o_d_valid), 32'd0);
        check("rst.a_ready", 32'(o_a_ready), 32'd0);
        check("rst.d_data",  o_d_data, 32'd0);
        check("rst.d_error", 32'(o_d_error), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        check("rel.a_ready_rst", 32'(o_a_ready), 32'd0);
        @(posedge i_clk); #1;
        check("rel.a_ready_idle", 32'(o_a_ready), 32'd1);

        xact("put_full", 3'd0, 2'd2, 4'd1, 10'h010, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'd0);
        xact("get1",     3'd4, 2'd2, 4'd2, 10'h010, 4'hF, 32'd0,        3'd1, 1'b0, 32'hDEADBEEF);
        xact("put_part", 3'd1, 2'd0, 4'd3, 10'h011, 4'h2, 32'h00005500, 3'd0, 1'b0, 32'd0);
        xact("get2",     3'd4, 2'd2, 4'd4, 10'h010, 4'hF, 32'd0,        3'd1, 1'b0, 32'hDEAD55EF);

        // Stalled response must hold every D field
        i_d_ready = 1'b0;
        drive_a(3'd4, 2'd2, 4'd7, 10'h010, 4'hF, 32'd0);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall.a_ready", 32'(o_a_ready), 32'd0);
            check_d("stall", 3'd1, 1'b0, 32'hDEAD55EF, 4'd7, 2'd2);
            @(posedge i_clk); #1;
        end
        i_d_ready = 1'b1;
        #1;
        check_d("stall_rel", 3'd1, 1'b0, 32'hDEAD55EF, 4'd7, 2'd2);
        @(posedge i_clk); #1;
        check("stall.one_beat", 32'(o_d_valid), 32'd0);

        // Halfword and partial writes
        xact("w40",   3'd0, 2'd2, 4'd1, 10'h040, 4'hF, 32'h11223344, 3'd0, 1'b0, 32'd0);
        xact("half",  3'd0, 2'd1, 4'd2, 10'h042, 4'hC, 32'hAABB0000, 3'd0, 1'b0, 32'd0);
        xact("pbyte", 3'd1, 2'd2, 4'd3, 10'h040, 4'h1, 32'hFFFFFFEE, 3'd0, 1'b0, 32'd0);
        xact("r40",   3'd4, 2'd2, 4'd4, 10'h040, 4'hF, 32'd0,        3'd1, 1'b0, 32'hAABB33EE);

        // Error cases leave memory alone
        xact("e_opc2",   3'd2, 2'd2, 4'd5, 10'h010, 4'hF, 32'h0,        3'd0, 1'b1, 32'd0);
        xact("e_size3",  3'd4, 2'd3, 4'd6, 10'h010, 4'hF, 32'h0,        3'd1, 1'b1, 32'd0);
        xact("e_align",  3'd4, 2'd2, 4'd7, 10'h012, 4'hF, 32'h0,        3'd1, 1'b1, 32'd0);
        xact("e_fmask",  3'd0, 2'd2, 4'd8, 10'h010, 4'h7, 32'h01234567, 3'd0, 1'b1, 32'd0);
        xact("e_pmask",  3'd1, 2'd0, 4'd9, 10'h011, 4'h1, 32'h000000AA, 3'd0, 1'b1, 32'd0);
        xact("reread",   3'd4, 2'd2, 4'hA, 10'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEAD55EF);

        for (int i = 0; i < 8; i++)
            xact("fill", 3'd0, 2'd2, 4'(i), 10'(10'h080 + 4 * i), 4'hF, 32'hA5000000 + 32'(i),
                 3'd0, 1'b0, 32'd0);

        // Back-to-back Gets, one per cycle
        i_d_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_a(3'd4, 2'd2, 4'(i ^ 5), 10'(10'h080 + 4 * i), 4'hF, 32'd0);
            #1;
            check("b2b.a_ready", 32'(o_a_ready), 32'd1);
            @(posedge i_clk); #1;
            check_d("b2b", 3'd1, 1'b0, 32'hA5000000 + 32'(i), 4'(i ^ 5), 2'd2);
        end
        i_a_valid = 1'b0;
        @(posedge i_clk); #1;
        check("b2b.drain", 32'(o_d_valid), 32'd0);

        // Get right behind a Put to the same word
        drive_a(3'd0, 2'd2, 4'd1, 10'h0C0, 4'hF, 32'hCAFEF00D);
        @(posedge i_clk); #1;
        check_d("raw_put", 3'd0, 1'b0, 32'd0, 4'd1, 2'd2);
        drive_a(3'd4, 2'd2, 4'd2, 10'h0C0, 4'hF, 32'd0);
        #1;
        check("raw.a_ready", 32'(o_a_ready), 32'd1);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        check_d("raw_get", 3'd1, 1'b0, 32'hCAFEF00D, 4'd2, 2'd2);
        @(posedge i_clk); #1;

        // Reset while a response is pending
        i_d_ready = 1'b0;
        drive_a(3'd4, 2'd2, 4'd3, 10'h010, 4'hF, 32'd0);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        check("mid.valid_before", 32'(o_d_valid), 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("mid.valid_async", 32'(o_d_valid), 32'd0);
        check("mid.a_ready",     32'(o_a_ready), 32'd0);
        check("mid.d_data",      o_d_data, 32'd0);
        check("mid.d_source",    32'(o_d_source), 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_d_ready = 1'b1;
        #1;
        check("mid.rel_a_ready0", 32'(o_a_ready), 32'd0);
        check("mid.rel_valid0",   32'(o_d_valid), 32'd0);
        @(posedge i_clk); #1;
        check("mid.rel_a_ready1", 32'(o_a_ready), 32'd1);
        check("mid.no_stale1",    32'(o_d_valid), 32'd0);
        @(posedge i_clk); #1;
        check("mid.no_stale2",    32'(o_d_valid), 32'd0);
        xact("post_rst", 3'd4, 2'd2, 4'hB, 10'h010, 4'hF, 32'd0, 3'd1, 1'b0, 32'hDEAD55EF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tlul_sram_slave.md
TLUL_SRAM_SLAVE -- requirements
Module: tlul_sram_slave

Interface
REQ-001 Parameter: ADDR_W, 10, byte-address width; memory depth = 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter: SRC_W, 4, width of the A/D source ID fields.
REQ-003 Port: i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: i_reset_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: i_a_valid  in  1  A-channel request valid.
REQ-006 Port: o_a_ready  out  1  A-channel ready.
REQ-007 Port: i_a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
REQ-008 Port: i_a_param  in  3  ignored.
REQ-009 Port: i_a_size  in  2  log2 of the byte count.
REQ-010 Port: i_a_source  in  SRC_W  request ID.
REQ-011 Port: i_a_address  in  ADDR_W  byte address.
REQ-012 Port: i_a_mask  in  4  byte-lane enables.
REQ-013 Port: i_a_data  in  32  write data.
REQ-014 Port: o_d_valid  out  1  D-channel response valid.
REQ-015 Port: i_d_ready  in  1  D-channel ready.
REQ-016 Port: o_d_opcode  out  3  0=AccessAck, 1=AccessAckData.
REQ-017 Port: o_d_param, o_d_sink  out  3, 1  constant 0.
REQ-018 Port: o_d_size  out  2  echo of accepted i_a_size.
REQ-019 Port: o_d_source  out  SRC_W  echo of accepted i_a_source.
REQ-020 Port: o_d_data  out  32  read data; 0 for AccessAck or on error.
REQ-021 Port: o_d_error  out  1  request denied.

Function
REQ-022 Acceptance occurs on a rising edge with i_a_valid && o_a_ready; it loads the single response register and sets o_d_valid on that same edge, giving 1-cycle request-to-response latency.
REQ-023 States: RST (i_reset_n low, or the first edge after release not yet seen), IDLE (o_d_valid=0), RESP (o_d_valid=1).
REQ-024 o_a_ready = 0 in RST; 1 in IDLE; in RESP it equals i_d_ready, combinationally, allowing one transfer per cycle back-to-back.
REQ-025 RST->IDLE on the first rising edge with i_reset_n high.
REQ-026 IDLE->RESP on acceptance.
REQ-027 RESP->IDLE on i_d_ready without acceptance.
REQ-028 RESP stays in RESP, with the register reloaded, on i_d_ready with simultaneous acceptance.
REQ-029 While o_d_valid=1 && i_d_ready=0, all o_d_* outputs are held stable.
REQ-030 Error when any of the following holds: opcode not in {0,1,4}; i_a_size>2; address not aligned to 2^size; PutFullData mask != contiguous mask for size/address; Get/PutPartial mask has bits outside the size/address lanes.
REQ-031 An errored request performs no memory write and produces o_d_error=1, o_d_data=0, and the opcode matching the request class (Get->1, otherwise 0).
REQ-032 A valid Put writes only the byte lanes with mask=1 at word index address[ADDR_W-1:2] and returns AccessAck with o_d_error=0.
REQ-033 A valid Get returns AccessAckData with the full 32-bit word, sampled at acceptance.
REQ-034 A Get accepted on the cycle after a Put to the same word returns the post-write data.

Reset
REQ-035 During i_reset_n=0, asynchronously: o_d_valid=0, o_a_ready=0, all o_d_* =0, state=RST.
REQ-036 Memory contents are not reset.
REQ-037 A reset asserted while a response is pending discards that response; no D beat is issued after release.

Verification
REQ-038 Release reset, write PutFullData addr 0x010 mask F data 0xDEADBEEF, then Get 0x010 -> AccessAck then AccessAckData 0xDEADBEEF, each o_d_valid exactly 1 cycle after acceptance.
REQ-039 Then PutPartialData addr 0x011 size 0 mask 0x2 data 0x00005500, then Get 0x010 -> data 0xDEAD55EF.
REQ-040 Hold i_d_ready=0 for 5 cycles during a pending Get with source 7 -> o_a_ready=0 and the D fields stable for all 5 cycles, then one beat with source 7.
REQ-041 Back-to-back Gets with i_d_ready=1 constant for 8 cycles -> 8 responses in 8 cycles, in order, with matching sources.
REQ-042 Opcode 2; Get with size 3; Get at 0x012 with size 2 -> each gives o_d_error=1 and data 0; memory unchanged on re-read.
REQ-043 Assert i_reset_n low while o_d_valid=1 -> o_d_valid falls without a clock edge; after release o_a_ready=0 for one edge, then 1, and no stale beat appears.
